// File: rtl/systolic_operand_feeder_if.sv
// Bundle of the signals between the operand feeder, the multiply controller
// and the 3x3 systolic array edges.
//   start, pause      : controller -> feeder commands
//   a_flat, b_flat    : full operand matrices, element [i][j] at [(i*N+j)*W +: W]
//   array_clear       : one-cycle clear pulse towards the array
//   perform_next      : array step strobe, aligned with a_left/b_top
//   a_left, b_top     : skewed edge operands (row i / column j at [k*W +: W])
//   busy, done        : operation status towards the controller
// The master modport is the controller side, the slave modport is the feeder.
interface systolic_operand_feeder_if #(
  parameter int N = 3,
  parameter int W = 8
);
  logic             start;
  logic             pause;
  logic [N*N*W-1:0] a_flat;
  logic [N*N*W-1:0] b_flat;
  logic             array_clear;
  logic             perform_next;
  logic [N*W-1:0]   a_left;
  logic [N*W-1:0]   b_top;
  logic             busy;
  logic             done;

  modport master (
    output start, pause, a_flat, b_flat,
    input  array_clear, perform_next, a_left, b_top, busy, done
  );

  modport slave (
    input  start, pause, a_flat, b_flat,
    output array_clear, perform_next, a_left, b_top, busy, done
  );
endinterface

// File: rtl/systolic_operand_feeder.sv
// Operand feeder for an NxN systolic multiply array.
// Latches A and B on an accepted start, pulses array_clear for one cycle,
// then streams skewed edges: row i of A is delayed i steps, column j of B is
// delayed j steps. 3N-2 strobed steps are issued (the last N-1 carry zeros
// to drain the diagonal), after which done pulses for one cycle.
// Ports:
//   CLK   : clock, all logic on posedge
//   RESET : synchronous active-high reset, aborts any operation
//   bus   : slave side of systolic_operand_feeder_if (see interface header)
// Every output is registered; the registers hold the values shown in the
// cycle that state_q describes, so strobe and operands always move together.
module systolic_operand_feeder #(
  parameter int N = 3,
  parameter int W = 8
) (
  input  logic                      CLK,
  input  logic                      RESET,
  systolic_operand_feeder_if.slave  bus
);

  localparam int STEPS = 3 * N - 2;
  localparam int SW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [SW-1:0] LAST_STEP = SW'(STEPS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    FEED  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [SW-1:0]      step_q, step_d;
  logic [N*N*W-1:0]   a_mat_q, a_mat_d;
  logic [N*N*W-1:0]   b_mat_q, b_mat_d;
  logic               array_clear_q, array_clear_d;
  logic               perform_next_q, perform_next_d;
  logic [N*W-1:0]     a_left_q, a_left_d;
  logic [N*W-1:0]     b_top_q, b_top_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               issue_s;

  // Left edge at step k: row i carries A[i][k-i] when that column exists.
  function automatic logic [N*W-1:0] left_edge(input logic [N*N*W-1:0] m,
                                               input logic [SW-1:0]    k);
    logic [N*W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      if ((int'(k) >= i) && ((int'(k) - i) < N)) begin
        r[i*W +: W] = m[(i*N + (int'(k) - i))*W +: W];
      end else begin
        r[i*W +: W] = '0;
      end
    end
    return r;
  endfunction

  // Top edge at step k: column j carries B[k-j][j] when that row exists.
  function automatic logic [N*W-1:0] top_edge(input logic [N*N*W-1:0] m,
                                              input logic [SW-1:0]    k);
    logic [N*W-1:0] r;
    r = '0;
    for (int j = 0; j < N; j++) begin
      if ((int'(k) >= j) && ((int'(k) - j) < N)) begin
        r[j*W +: W] = m[((int'(k) - j)*N + j)*W +: W];
      end else begin
        r[j*W +: W] = '0;
      end
    end
    return r;
  endfunction

  // Next-state, step counter, operand latch and next output values.
  always_comb begin
    state_d        = state_q;
    step_d         = step_q;
    a_mat_d        = a_mat_q;
    b_mat_d        = b_mat_q;
    array_clear_d  = 1'b0;
    perform_next_d = 1'b0;
    a_left_d       = '0;
    b_top_d        = '0;
    busy_d         = 1'b0;
    done_d         = 1'b0;
    issue_s        = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d       = CLEAR;
          a_mat_d       = bus.a_flat;
          b_mat_d       = bus.b_flat;
          array_clear_d = 1'b1;
          busy_d        = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      CLEAR: begin
        // Step 0 (or a pause bubble) is decided on the way out of CLEAR.
        state_d = FEED;
        step_d  = '0;
        busy_d  = 1'b1;
        issue_s = 1'b1;
      end
      FEED: begin
        // step_q is the step on display; it only advances once that step
        // was actually strobed, so pause bubbles hold it.
        if (perform_next_q && (step_q == LAST_STEP)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          if (perform_next_q) begin
            step_d = step_q + SW'(1);
          end else begin
            step_d = step_q;
          end
          busy_d  = 1'b1;
          issue_s = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (issue_s && !bus.pause) begin
      perform_next_d = 1'b1;
      a_left_d       = left_edge(a_mat_q, step_d);
      b_top_d        = top_edge(b_mat_q, step_d);
    end else begin
      perform_next_d = 1'b0;
    end
  end

  // State, step counter, latched operands and registered outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q        <= IDLE;
      step_q         <= '0;
      a_mat_q        <= '0;
      b_mat_q        <= '0;
      array_clear_q  <= 1'b0;
      perform_next_q <= 1'b0;
      a_left_q       <= '0;
      b_top_q        <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      step_q         <= step_d;
      a_mat_q        <= a_mat_d;
      b_mat_q        <= b_mat_d;
      array_clear_q  <= array_clear_d;
      perform_next_q <= perform_next_d;
      a_left_q       <= a_left_d;
      b_top_q        <= b_top_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign bus.array_clear  = array_clear_q;
  assign bus.perform_next = perform_next_q;
  assign bus.a_left       = a_left_q;
  assign bus.b_top        = b_top_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;

endmodule
